// File: rtl/ulbf_data_axis_reader.sv
// rtl/ulbf_data_axis_reader.sv - RAM port-B playback sequencer feeding an AXI4-Stream master
// Optional feature macro: ULBF_DATA_LOOP_EN (continuous frame replay while cfg_loop is high)
module ulbf_data_axis_reader #(
  parameter int DATA_WIDTH       = 64,
  parameter int RAM_DEPTH        = 4096,
  parameter int RAM_READ_LATENCY = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst,
  input  logic                  start,
  input  logic [15:0]           cfg_start_addr,
  input  logic [15:0]           cfg_num_words,
  input  logic                  cfg_loop,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           ram_addrb,
  output logic                  ram_enb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LT = RAM_READ_LATENCY;

  localparam logic [15:0]   LAST_ADDR  = 16'(RAM_DEPTH - 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);

  logic [1:0]            state;
  logic [15:0]           base_addr;
  logic [15:0]           num_words;
  logic [15:0]           idx;
  logic [15:0]           addr;
  logic [15:0]           start_mod;
  logic [LT-1:0]         vld_sr;
  logic [LT-1:0]         last_sr;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         outstanding_nxt;
  logic                  issue;
  logic                  issue_last;
  logic                  push;
  logic                  pop;
  logic                  loop_again;

  // Credit counts every word not yet handed downstream: reads in flight plus FIFO entries.
  always_comb begin
    start_mod       = 16'({16'd0, cfg_start_addr} % RAM_DEPTH);
    issue           = (state == ST_RUN) && (outstanding < CREDIT_MAX);
    issue_last      = issue && (idx == num_words - 16'd1);
    push            = vld_sr[LT-1];
    pop             = m_axis_tvalid && m_axis_tready;
    outstanding_nxt = outstanding + CW'(issue) - CW'(pop);
  end

`ifdef ULBF_DATA_LOOP_EN
  assign loop_again = issue_last && cfg_loop;
`else
  logic loop_unused;
  assign loop_unused = cfg_loop;
  assign loop_again  = 1'b0;
`endif

  assign ram_enb       = issue;
  assign ram_addrb     = addr;
  assign busy          = (state != ST_IDLE);
  assign m_axis_tvalid = (fifo_cnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];

  // Frame sequencing: start acceptance, address walk with wrap, drain and done pulse.
  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      state       <= ST_IDLE;
      base_addr   <= '0;
      num_words   <= '0;
      idx         <= '0;
      addr        <= '0;
      done        <= 1'b0;
      outstanding <= '0;
    end else begin
      done        <= 1'b0;
      outstanding <= outstanding_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_num_words != 16'd0) begin
              base_addr <= start_mod;
              addr      <= start_mod;
              num_words <= cfg_num_words;
              idx       <= '0;
              state     <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (issue_last) begin
              idx  <= '0;
              addr <= base_addr;
              if (!loop_again) state <= ST_DRAIN;
            end else begin
              idx  <= idx + 16'd1;
              addr <= (addr == LAST_ADDR) ? 16'd0 : addr + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding_nxt == '0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-latency tracker: valid and last flags ride alongside each issued read.
  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr  <= (vld_sr << 1) | LT'(issue);
      last_sr <= (last_sr << 1) | LT'(issue_last);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset because the read side is gated by occupancy.
  always_ff @(posedge m_axis_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_doutb;
      fifo_last[wr_ptr] <= last_sr[LT-1];
    end
  end

  // A push into a full FIFO would mean the credit accounting is broken.
  always @(posedge m_axis_clk) begin
    if (!m_axis_rst) assert (!(push && !pop && fifo_cnt == CREDIT_MAX));
  end

endmodule
